// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_arb_pkg
//  Brief    : Shared types and constants for the UART transmit arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  // Width of one transmitted character
  localparam int BYTE_W = 8;

  // Arbiter message/byte sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } arb_state_e;

  // Bits needed for a counter that must be able to hold max_count itself
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin selector. Returns the first asserted
//             valid bit at or above the pointer, wrapping at NUM_REQ.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam logic [IDX_W:0]     N_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  // One spare bit so ptr + offset can exceed NUM_REQ before being wrapped
  logic [IDX_W:0] cand;

  // Scan NUM_REQ candidates starting at the pointer; the first hit wins
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!any_o && valid_i[cand[IDX_W-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
    onehot_o = any_o ? (ONE << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin sharing of one UART byte transmitter between
//             NUM_REQ valid/ready/last byte streams. A grant is held for a
//             whole message and the transmitter is paced on its rts output.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_ena_o,
  input  logic                 tx_rts_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 ack_err_o
);

  import uart_arb_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q,  state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gidx_q,   gidx_d;
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic               busy_q,   busy_d;
  logic               last_q,   last_d;
  logic               ena_q,    ena_d;
  logic               err_q,    err_d;
  logic [BYTE_W-1:0]  data_q,   data_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [BYTE_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               send_fire;
  logic [CNT_W-1:0]   cnt_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i  (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  // AND-OR mux of the granted requester's byte, valid and last flag
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data  = sel_data | req_data_i[i*BYTE_W +: BYTE_W];
        sel_valid = sel_valid | req_valid_i[i];
        sel_last  = sel_last | req_last_i[i];
      end
    end
  end

  // Only the owner sees ready, and only while the transmitter can take a byte
  assign req_ready_o = (state_q == SEND) ? (grant_q & {NUM_REQ{tx_rts_i}}) : '0;
  assign send_fire   = (state_q == SEND) && sel_valid && tx_rts_i;
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // Next-state logic for message sequencing, byte launch and ack supervision
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    last_d   = last_q;
    ena_d    = 1'b0;
    err_d    = err_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // data only moves here, when rts says the transmitter is idle
        if (send_fire) begin
          data_d  = sel_data;
          ena_d   = 1'b1;
          last_d  = sel_last;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_rts_i) begin
          state_d = WAIT_HI;
        end else begin
          cnt_d = cnt_inc;
          // give up waiting for the ack but still follow rts afterwards
          if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (tx_rts_i) begin
          if (!last_q) begin
            state_d = SEND;
          end else begin
            grant_d  = '0;
            busy_d   = 1'b0;
            rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; the async reset abandons any partial message
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      ena_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      ena_q    <= ena_d;
      err_q    <= err_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_data_o = data_q;
  assign tx_ena_o  = ena_q;
  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign ack_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Self-checking bench for uart_tx_arbiter with a UART transmitter
//             model, a line decoder and an expected-byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam int CLK_FREQ    = 1_000_000;
  localparam int BAUD        = 115_200;
  localparam int BIT_CYC     = CLK_FREQ / BAUD;

  logic                 clk_i    = 1'b0;
  logic                 arst_n_i = 1'b1;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [7:0]           tx_data_o;
  logic                 tx_ena_o;
  logic                 tx_rts_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;
  logic                 ack_err_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_ena_o    (tx_ena_o),
    .tx_rts_i    (tx_rts_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .ack_err_o   (ack_err_o)
  );

  // ---------------- transmitter model (8N1, rts high when idle) ----------
  logic       m_rts, m_txd;
  logic [8:0] m_sh;
  logic [3:0] m_bit;
  logic [7:0] m_cyc;
  logic       stub_rts = 1'b0;

  assign tx_rts_i = stub_rts ? 1'b1 : m_rts;

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      m_rts <= 1'b1; m_txd <= 1'b1; m_sh <= '0; m_bit <= '0; m_cyc <= '0;
    end else if (m_rts) begin
      if (tx_ena_o) begin
        m_rts <= 1'b0; m_txd <= 1'b0; m_sh <= {1'b1, tx_data_o};
        m_bit <= '0;   m_cyc <= '0;
      end
    end else if (m_cyc == 8'(BIT_CYC - 1)) begin
      m_cyc <= '0;
      if (m_bit == 4'd9) begin
        m_rts <= 1'b1;
      end else begin
        m_txd <= m_sh[0]; m_sh <= m_sh >> 1; m_bit <= m_bit + 4'd1;
      end
    end else begin
      m_cyc <= m_cyc + 8'd1;
    end
  end

  // ---------------- tables, queues, counters -----------------------------
  typedef struct {
    int                 req;
    logic [7:0]         data;
    logic               last;
    logic [NUM_REQ-1:0] exp_grant;
  } vec_t;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [7:0]         data;
  } exp_t;

  vec_t               tbl [26];
  exp_t               sb_q [$];
  exp_t               mon_e;
  logic [8:0]         rq [NUM_REQ][$];
  logic [7:0]         rx_q [$];
  logic [7:0]         rx_byte;
  logic [NUM_REQ-1:0] hold = '0;
  logic [NUM_REQ-1:0] hs_pend;
  int                 n_tests = 0;
  int                 n_fail  = 0;
  int                 bad_rdy = 0;
  int                 bad_grant = 0;
  int                 ena_cnt = 0;
  logic [NUM_REQ-1:0] watch_grant = '0;
  bit                 watch_en = 1'b0;
  logic               ena_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      rq[tbl[k].req].push_back({tbl[k].last, tbl[k].data});
      sb_q.push_back('{grant: tbl[k].exp_grant, data: tbl[k].data});
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    sb_q.delete();
    hold    = '0;
    hs_pend = '0;
  endtask

  task automatic do_reset();
    arst_n_i = 1'b0;
    flush();
    repeat (3) @(posedge clk_i);
    #2 arst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 rx_q.delete();
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      if (sb_q.size() == 0 && !busy_o && rq_empty()) break;
      @(posedge clk_i); #2;
    end
    check({name, "_done"}, 32'(k < max_cyc), 1);
  endtask

  task automatic wait_ena(input string name, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(posedge clk_i); #2;
      if (tx_ena_o) break;
    end
    check(name, 32'(k < max_cyc), 1);
  endtask

  // ---------------- requester driver (inputs change on negedge) ----------
  initial begin
    req_valid_i = '0; req_data_i = '0; req_last_i = '0; hs_pend = '0;
    forever begin
      @(negedge clk_i);
      for (int i = 0; i < NUM_REQ; i++)
        if (hs_pend[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      hs_pend = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() != 0 && !hold[i]) begin
          req_valid_i[i]       = 1'b1;
          req_data_i[i*8 +: 8] = rq[i][0][7:0];
          req_last_i[i]        = rq[i][0][8];
        end else begin
          req_valid_i[i] = 1'b0;
          req_last_i[i]  = 1'b0;
        end
      end
      #1 hs_pend = req_valid_i & req_ready_o;
    end
  end

  // ---------------- scoreboard monitor and invariants --------------------
  initial begin
    ena_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if ((req_ready_o & ~grant_o) != '0) bad_rdy++;
      if (watch_en && busy_o && grant_o !== watch_grant) bad_grant++;
      if (tx_ena_o) begin
        ena_cnt++;
        check("ena_rts_high", tx_rts_i, 1);
        check("ena_one_cycle", ena_prev, 0);
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ena: got data 0x%0h grant %b, expected no pulse", tx_data_o, grant_o);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_grant", grant_o, mon_e.grant);
          check("sb_data", tx_data_o, mon_e.data);
        end
      end
      ena_prev = tx_ena_o;
    end
  end

  // ---------------- serial line decoder ----------------------------------
  initial begin
    forever begin
      @(posedge clk_i); #2;
      if (arst_n_i && m_txd === 1'b0) begin
        repeat (BIT_CYC / 2) @(posedge clk_i);
        for (int b = 0; b < 8; b++) begin
          repeat (BIT_CYC) @(posedge clk_i);
          #2 rx_byte[b] = m_txd;
        end
        rx_q.push_back(rx_byte);
        repeat (BIT_CYC) @(posedge clk_i);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------------------------------
  initial begin
    int k, drops, gbad, rdy0, ena0;
    // {requester, byte, last, expected grant} in expected transmit order
    tbl[0]  = '{0, 8'h48, 1'b0, 4'b0001};  tbl[1]  = '{0, 8'h69, 1'b1, 4'b0001};
    tbl[2]  = '{1, 8'hA1, 1'b0, 4'b0010};  tbl[3]  = '{1, 8'hA2, 1'b0, 4'b0010};
    tbl[4]  = '{1, 8'hA3, 1'b1, 4'b0010};  tbl[5]  = '{3, 8'hB1, 1'b0, 4'b1000};
    tbl[6]  = '{3, 8'hB2, 1'b0, 4'b1000};  tbl[7]  = '{3, 8'hB3, 1'b1, 4'b1000};
    tbl[8]  = '{0, 8'hC0, 1'b1, 4'b0001};  tbl[9]  = '{1, 8'hC1, 1'b1, 4'b0010};
    tbl[10] = '{2, 8'hC2, 1'b1, 4'b0100};  tbl[11] = '{3, 8'hC3, 1'b1, 4'b1000};
    tbl[12] = '{0, 8'hD0, 1'b1, 4'b0001};  tbl[13] = '{1, 8'hD1, 1'b1, 4'b0010};
    tbl[14] = '{2, 8'h20, 1'b0, 4'b0100};  tbl[15] = '{2, 8'h21, 1'b0, 4'b0100};
    tbl[16] = '{2, 8'h22, 1'b1, 4'b0100};  tbl[17] = '{0, 8'h5A, 1'b1, 4'b0001};
    tbl[18] = '{1, 8'hE7, 1'b1, 4'b0010};  tbl[19] = '{0, 8'h11, 1'b1, 4'b0001};
    tbl[20] = '{3, 8'h31, 1'b0, 4'b1000};  tbl[21] = '{3, 8'h32, 1'b0, 4'b1000};
    tbl[22] = '{3, 8'h33, 1'b0, 4'b1000};  tbl[23] = '{3, 8'h34, 1'b1, 4'b1000};
    tbl[24] = '{0, 8'h77, 1'b1, 4'b0001};  tbl[25] = '{3, 8'h88, 1'b1, 4'b1000};

    // reset values
    #1 arst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_ready", req_ready_o, 0);
    check("rst_data", tx_data_o, 0);
    check("rst_ena", tx_ena_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ack_err", ack_err_o, 0);
    arst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;

    // single requester "Hi"
    rx_q.delete();
    watch_grant = 4'b0001; watch_en = 1'b1; ena_cnt = 0;
    load(0, 1);
    wait_done("t1", 1000);
    watch_en = 1'b0;
    check("t1_ena_count", ena_cnt, 2);
    check("t1_grant_held", bad_grant, 0);
    check("t1_busy_end", busy_o, 0);
    check("t1_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("t1_rx_H", rx_q[0], 8'h48);
      check("t1_rx_i", rx_q[1], 8'h69);
    end

    // contention req1 vs req3 from pointer 0
    do_reset();
    load(2, 7);
    wait_done("t2", 2000);
    check("t2_ready_only_owner", bad_rdy, 0);

    // fairness with four continuous single-byte requesters
    do_reset();
    load(8, 13);
    wait_done("t3", 3000);

    // lock hold: req2 pauses mid-message while req0 waits
    do_reset();
    load(14, 16);
    for (k = 0; k < 20; k++) begin
      @(posedge clk_i); #2;
      if (grant_o == 4'b0100) break;
    end
    check("t4_grant_req2", grant_o, 4'b0100);
    load(17, 17);
    wait_ena("t4_first_ena", 200);
    hold[2] = 1'b1;
    for (k = 0; k < 300; k++) begin @(posedge clk_i); #2; if (!tx_rts_i) break; end
    for (k = 0; k < 300; k++) begin if (tx_rts_i) break; @(posedge clk_i); #2; end
    check("t4_byte_finished", 32'(k < 300), 1);
    ena0 = ena_cnt; gbad = 0; rdy0 = 0;
    repeat (50) begin
      @(posedge clk_i); #2;
      if (grant_o !== 4'b0100) gbad++;
      if (req_ready_o[0]) rdy0++;
    end
    check("t4_hold_no_ena", ena_cnt - ena0, 0);
    check("t4_hold_grant", gbad, 0);
    check("t4_hold_req0_ready", rdy0, 0);
    hold[2] = 1'b0;
    wait_done("t4", 2000);

    // ack timeout with rts stuck high
    do_reset();
    stub_rts = 1'b1;
    load(18, 18);
    wait_ena("t5_ena", 50);
    check("t5_ack_before", ack_err_o, 0);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk_i); #2;
      if (ack_err_o) break;
    end
    check("t5_ack_latency", k, ACK_TIMEOUT);
    drops = 0;
    repeat (30) begin @(posedge clk_i); #2; if (!ack_err_o) drops++; end
    check("t5_ack_sticky", drops, 0);
    wait_done("t5", 100);
    do_reset();
    stub_rts = 1'b0;
    check("t5_ack_cleared", ack_err_o, 0);

    // reset in the middle of a 4-byte message with pointer at 1
    load(19, 19);
    wait_done("t6_pre", 1000);
    load(20, 23);
    wait_ena("t6_ena1", 200);
    wait_ena("t6_ena2", 400);
    repeat (20) @(posedge clk_i);
    #2 check("t6_in_wait_hi", tx_rts_i, 0);
    arst_n_i = 1'b0;
    flush();
    #1;
    check("t6_rst_ready", req_ready_o, 0);
    check("t6_rst_ena", tx_ena_o, 0);
    check("t6_rst_grant", grant_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_data", tx_data_o, 0);
    repeat (3) @(posedge clk_i);
    #2 arst_n_i = 1'b1;
    ena0 = ena_cnt;
    repeat (100) @(posedge clk_i);
    #2 check("t6_no_ena_after_rst", ena_cnt - ena0, 0);
    load(24, 25);
    wait_done("t6_post", 2000);
    check("all_ready_only_owner", bad_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_txd byte transmitter between NUM_REQ independent byte-stream requesters (e.g. several Avalon-MM slave ports or debug sources). Requesters offer bytes on valid/ready/last streams. The arbiter grants one requester per message, round-robin, and holds the grant until the byte flagged last has finished transmitting. It drives the transmitter's d/ena inputs and paces itself on the transmitter's rts output.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 4, max cycles to wait for tx_rts_i to drop after an ena pulse before flagging an error (>=2)

Ports:
clk_i  input  1  clock
arst_n_i  input  1  reset, asynchronous, active-low
req_valid_i  input  NUM_REQ  per-requester byte valid
req_data_i  input  NUM_REQ*8  per-requester byte; requester i on bits [8i+7:8i]
req_last_i  input  NUM_REQ  byte is final byte of message
req_ready_o  output  NUM_REQ  per-requester byte accept
tx_data_o  output  8  byte to transmitter d
tx_ena_o  output  1  one-cycle start pulse to transmitter ena
tx_rts_i  input  1  transmitter idle/ready-to-send
grant_o  output  NUM_REQ  one-hot current owner, 0 when idle
busy_o  output  1  message in progress
ack_err_o  output  1  sticky: transmitter failed to acknowledge an ena pulse

Behaviour:
- Reset values: req_ready_o=0, tx_data_o=0, tx_ena_o=0, grant_o=0, busy_o=0, ack_err_o=0. Internal state: FSM=IDLE, rr pointer=0, timeout counter=0.
- Reset mid-message: partial message dropped, no further ena. The transmitter shares arst_n_i.
- FSM states: IDLE, SEND, WAIT_LO, WAIT_HI.
- IDLE: if any req_valid_i, pick the first valid index searching from the rr pointer upward with wrap. Register the one-hot grant_o and set busy_o. Next state SEND. Grant appears 1 cycle after valid is seen.
- SEND: req_ready_o[g] = tx_rts_i (combinational); all other ready bits 0. When req_valid_i[g] & req_ready_o[g]:
  - register tx_data_o = req_data_i[g] and tx_ena_o=1 for exactly one cycle (aligned, next cycle);
  - latch last flag;
  - go to WAIT_LO.
  If the granted requester drops valid, stay in SEND. The lock holds and no other requester is served.
- WAIT_LO: wait for tx_rts_i=0, then go to WAIT_HI. The counter increments each cycle tx_rts_i stays 1. On reaching ACK_TIMEOUT: set ack_err_o, go to WAIT_HI. ack_err_o clears only on reset.
- WAIT_HI: wait for tx_rts_i=1. Then:
  - if the latched last flag is 0, go to SEND;
  - otherwise clear grant_o and busy_o, set rr pointer = (g+1) mod NUM_REQ, go to IDLE.
- tx_data_o holds its value between bytes and is never changed while the transmitter is busy.
- At most one ena pulse per byte; never an ena while tx_rts_i=0.
- Simultaneous requests are resolved by rr order only. The fairness bound is that each requester waits at most NUM_REQ-1 messages.
- Single-byte message (last=1 on first byte) is legal.
- Throughput: 1 IDLE cycle between messages, 0 extra cycles between bytes beyond the rts turnaround.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, SEND, WAIT_LO, WAIT_HI), BYTE_W=8 constant, timeout counter width function.
- One sub-module, rr_pick: combinational round-robin selector with inputs valid vector and pointer, output one-hot plus index.
- FSM, data mux and timeout counter stay in uart_tx_arbiter.

Test Plan:
- Single requester: req0 sends 0x48,0x69 (last on 0x69) with a uart_txd model at CLK_FREQ=1 MHz, BAUD=115200. Required: two ena pulses, tx_data_o 0x48 then 0x69, grant_o=0001 throughout, busy_o low after the second byte, and the line decodes as "Hi".
- Contention: req1 and req3 each valid with 3-byte messages from reset (pointer=0). Required: req1's full message first, then req3's, with no interleaving. req3's ready stays 0 until grant_o=1000.
- Fairness: all 4 requesters continuously send 1-byte messages. Required: grant sequence 0,1,2,3,0,1 and no requester skipped.
- Lock hold: req2 granted, deasserts valid for 50 cycles mid-message while req0 is valid. Required: grant_o stays 0100, no ena pulses, and the message resumes when req2 revalidates.
- Timeout: stub tx_rts_i tied 1. Required: ack_err_o rises exactly ACK_TIMEOUT cycles after the first ena, and stays high until arst_n_i.
- Reset mid-message: assert arst_n_i low during WAIT_HI of byte 2 of 4. Required: all outputs at reset values, pointer=0, and the next message starts cleanly from IDLE.
